// File: rtl/sqrt_datapath.sv
// Iterative restoring integer square root, two radicand bits per cycle.
// Sequenced by start/stop strobes from the run/busy controller; results are committed only on stop.
module sqrt_datapath #(
    parameter int NBITSIN = 32
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 stop,
    input  logic [NBITSIN-1:0]   datain,
    output logic [NBITSIN/2-1:0] sqrt,
    output logic [NBITSIN/2:0]   remainder,
    output logic                 valid,
    output logic                 done,
    output logic                 overrun
);
    localparam int H  = NBITSIN / 2;
    localparam int IW = $clog2(H + 1);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

    state_t               state_q, state_d;
    logic [NBITSIN-1:0]   opnd_q, opnd_d;
    logic [H+1:0]         rem_q, rem_d;
    logic [H-1:0]         root_q, root_d;
    logic [IW-1:0]        iter_q, iter_d;
    logic [H-1:0]         sqrt_q, sqrt_d;
    logic [H:0]           remo_q, remo_d;
    logic                 valid_q, valid_d;
    logic                 overrun_q, overrun_d;

    logic [H+3:0]         rem_sh, sub, diff;
    logic                 ge;

    // Partial remainder stays below 2^(H+1), so truncating the trial to H+2 bits is lossless.
    always_comb begin
        rem_sh = {rem_q, opnd_q[NBITSIN-1:NBITSIN-2]};
        sub    = {2'b00, root_q, 2'b01};
        diff   = rem_sh - sub;
        ge     = (rem_sh >= sub);
    end

    always_comb begin
        state_d   = state_q;
        opnd_d    = opnd_q;
        rem_d     = rem_q;
        root_d    = root_q;
        iter_d    = iter_q;
        sqrt_d    = sqrt_q;
        remo_d    = remo_q;
        valid_d   = 1'b0;
        overrun_d = overrun_q;
        if (start) begin
            opnd_d    = datain;
            rem_d     = '0;
            root_d    = '0;
            iter_d    = '0;
            overrun_d = 1'b0;
            state_d   = S_CALC;
        end else begin
            case (state_q)
                S_CALC: begin
                    rem_d  = ge ? (H+2)'(diff) : (H+2)'(rem_sh);
                    root_d = {root_q[H-2:0], ge};
                    opnd_d = {opnd_q[NBITSIN-3:0], 2'b00};
                    iter_d = iter_q + IW'(1);
                    if (stop) overrun_d = 1'b1;
                    if (iter_q == IW'(H - 1)) state_d = S_DONE;
                end
                S_DONE: begin
                    if (stop) begin
                        sqrt_d  = root_q;
                        remo_d  = rem_q[H:0];
                        valid_d = 1'b1;
                        state_d = S_IDLE;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            opnd_q    <= '0;
            rem_q     <= '0;
            root_q    <= '0;
            iter_q    <= '0;
            sqrt_q    <= '0;
            remo_q    <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            opnd_q    <= opnd_d;
            rem_q     <= rem_d;
            root_q    <= root_d;
            iter_q    <= iter_d;
            sqrt_q    <= sqrt_d;
            remo_q    <= remo_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
        end
    end

    assign sqrt      = sqrt_q;
    assign remainder = remo_q;
    assign valid     = valid_q;
    assign done      = (state_q == S_DONE);
    assign overrun   = overrun_q;
endmodule
